pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one parameter: TIMEOUT, default 255, the number of consecutive memory-wait cycles after which mem_timeout asserts (legal range 1..65535).
REQ-002 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-003 The block SHALL provide the following ports, one per line as name, direction, width, meaning:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- rs1_dec, rs2_dec  in  5 each  source register addresses of the instruction now being decoded.
- rs1_used_dec, rs2_used_dec  in  1 each  decoder source-use flags.
- rd_EX  in  5  destination register of the instruction in EX.
- rf_wr_en_EX  in  1  EX instruction writes the register file.
- load_EX  in  1  EX instruction is a load (dm_rd_ctrl nonzero).
- redirect_EX  in  1  taken branch or jump resolved in EX.
- mem_req  in  1  data-memory access active in MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_fe  out  1  hold PC and the IF register.
- flush_if  out  1  invalidate the IF register (insert NOP).
- stall_idc  out  1  hold the decode-stage register.
- flush_idc  out  1  load a bubble into the decode-stage register.
- stall_ex  out  1  hold the EX-stage register.
- stall_mem  out  1  hold the MEM-stage register.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  32  count of cycles with stall_fe=1.
- redirect_count  out  32  count of accepted redirects.

Function
REQ-004 The block SHALL compute mem_wait = mem_req AND NOT mem_ready combinationally.
REQ-005 The block SHALL compute load_use = load_EX AND rf_wr_en_EX AND (rd_EX != 0) AND ((rs1_used_dec AND rs1_dec == rd_EX) OR (rs2_used_dec AND rs2_dec == rd_EX)) combinationally.
REQ-006 The block SHALL implement a two-state FSM with states RUN and SHADOW, where SHADOW means one more wrong-path fetch must be discarded.
REQ-007 Outputs SHALL be combinational from state and inputs, with priority mem_wait > redirect/SHADOW > load_use.
REQ-008 When mem_wait=1, in any state, the block SHALL drive stall_fe=stall_idc=stall_ex=stall_mem=1 and flush_if=flush_idc=0, and the state SHALL be held.
REQ-009 When mem_wait=0 and redirect_EX=1 in RUN, the block SHALL drive flush_if=1 and flush_idc=1 with all stalls 0, move to SHADOW next cycle, and increment redirect_count by 1.
REQ-010 In SHADOW with mem_wait=0, the block SHALL drive flush_if=1, flush_idc=0 and all stalls 0, then return to RUN; load_use and redirect_EX SHALL be ignored in that cycle.
REQ-011 When in RUN with mem_wait=0, redirect_EX=0 and load_use=1, the block SHALL drive stall_fe=1, stall_idc=0, flush_idc=1 and flush_if=0, giving exactly one bubble; no extra stall cycle SHALL follow, because EX then holds the bubble.
REQ-012 The block SHALL never assert stall_idc and flush_idc together, nor stall_fe and flush_if together.
REQ-013 A redirect_EX held during mem_wait SHALL be accepted only on the first cycle with mem_wait=0, and counted once.
REQ-014 A 16-bit wait counter SHALL increment on each mem_wait cycle, saturate at 65535, and clear on any cycle with mem_wait=0.
REQ-015 mem_timeout SHALL set on the clock edge at which the wait counter reaches TIMEOUT and SHALL stay set until reset.
REQ-016 stall_cycles SHALL increment on every cycle with stall_fe=1, wrapping modulo 2^32; redirect_count SHALL wrap modulo 2^32.

Reset
REQ-017 While reset=1 at a rising edge, the block SHALL set state=RUN and clear the wait counter, mem_timeout, stall_cycles and redirect_count to 0.
REQ-018 Combinational outputs SHALL still follow REQ-007..011 during reset; reset mid-SHADOW SHALL drop the pending flush.

Verification
REQ-019 Load-use: load_EX=1, rf_wr_en_EX=1, rd_EX=5, rs1_dec=5, rs1_used_dec=1 -> one cycle of stall_fe=1, flush_idc=1; stall_cycles=1.
REQ-020 x0 load: same as REQ-019 but rd_EX=0 -> no stall and no flush.
REQ-021 Redirect: redirect_EX=1 for one cycle in RUN -> cycle N: flush_if=1, flush_idc=1; cycle N+1: flush_if=1 only; redirect_count=1.
REQ-022 Memory wait with redirect: mem_req=1, mem_ready=0 for 3 cycles with redirect_EX=1 -> 3 cycles of all stalls and no flush, then the redirect sequence; redirect_count=1, stall_cycles=3.
REQ-023 Timeout: TIMEOUT=4, mem_wait held for 6 cycles -> mem_timeout=1 after the 4th edge; it stays 1 after mem_ready rises; reset clears it.
REQ-024 Counter wrap: preload stall_cycles=0xFFFFFFFF (force), then one stall cycle -> stall_cycles=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-unit signal bundle between the pipeline (master) and the hazard controller (slave)
//   Pipeline to controller: decode-stage source registers and use flags, EX-stage destination and
//     load/write/redirect flags, MEM-stage request/ready.
//   Controller to pipeline: per-stage stall/flush, sticky memory timeout, stall and redirect counters.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  rs1_dec;
  logic [4:0]  rs2_dec;
  logic        rs1_used_dec;
  logic        rs2_used_dec;
  logic [4:0]  rd_EX;
  logic        rf_wr_en_EX;
  logic        load_EX;
  logic        redirect_EX;
  logic        mem_req;
  logic        mem_ready;
  logic        stall_fe;
  logic        flush_if;
  logic        stall_idc;
  logic        flush_idc;
  logic        stall_ex;
  logic        stall_mem;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] redirect_count;
  modport master (
    output rs1_dec, rs2_dec, rs1_used_dec, rs2_used_dec, rd_EX, rf_wr_en_EX, load_EX,
           redirect_EX, mem_req, mem_ready,
    input  stall_fe, flush_if, stall_idc, flush_idc, stall_ex, stall_mem, mem_timeout,
           stall_cycles, redirect_count
  );
  modport slave (
    input  rs1_dec, rs2_dec, rs1_used_dec, rs2_used_dec, rd_EX, rf_wr_en_EX, load_EX,
           redirect_EX, mem_req, mem_ready,
    output stall_fe, flush_if, stall_idc, flush_idc, stall_ex, stall_mem, mem_timeout,
           stall_cycles, redirect_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for load-use hazards, EX redirects and memory waits
//   clk, reset : rising-edge clock, synchronous active-high reset
//   hz (slave) : hazard inputs from decode/EX/MEM; stall/flush controls, sticky mem_timeout,
//                stall_cycles (cycles with stall_fe) and redirect_count (accepted redirects)
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_hazard_ctrl_if.slave  hz
);
  typedef enum logic {RUN, SHADOW} state_t;
  state_t      state_q, state_d;
  logic        mem_wait, load_use, redir_acc;
  logic [15:0] wait_q, wait_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;
  assign mem_wait = hz.mem_req & ~hz.mem_ready;
  assign load_use = hz.load_EX & hz.rf_wr_en_EX & (hz.rd_EX != 5'd0) &
                    ((hz.rs1_used_dec & (hz.rs1_dec == hz.rd_EX)) |
                     (hz.rs2_used_dec & (hz.rs2_dec == hz.rd_EX)));
  // a redirect is only taken from RUN once memory is no longer stalling the pipe
  assign redir_acc = ~mem_wait & (state_q == RUN) & hz.redirect_EX;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= 16'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
      redir_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end
  // SHADOW lasts exactly one non-waiting cycle: the second wrong-path fetch
  always_comb begin
    state_d = mem_wait ? state_q : (redir_acc ? SHADOW : RUN);
  end
  always_comb begin
    hz.stall_fe  = 1'b0;
    hz.flush_if  = 1'b0;
    hz.stall_idc = 1'b0;
    hz.flush_idc = 1'b0;
    hz.stall_ex  = 1'b0;
    hz.stall_mem = 1'b0;
    if (mem_wait) begin
      hz.stall_fe  = 1'b1;
      hz.stall_idc = 1'b1;
      hz.stall_ex  = 1'b1;
      hz.stall_mem = 1'b1;
    end else if (state_q == SHADOW) begin
      hz.flush_if = 1'b1;
    end else if (hz.redirect_EX) begin
      hz.flush_if  = 1'b1;
      hz.flush_idc = 1'b1;
    end else if (load_use) begin
      // decode keeps advancing into a bubble, so the dependent instruction re-decodes once
      hz.stall_fe  = 1'b1;
      hz.flush_idc = 1'b1;
    end
  end
  always_comb begin
    wait_d      = mem_wait ? ((wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1) : 16'd0;
    timeout_d   = timeout_q | (wait_d == 16'(TIMEOUT));
    stall_cnt_d = stall_cnt_q + {31'd0, hz.stall_fe};
    redir_cnt_d = redir_cnt_q + {31'd0, redir_acc};
  end
  assign hz.mem_timeout    = timeout_q;
  assign hz.stall_cycles   = stall_cnt_q;
  assign hz.redirect_count = redir_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int unsigned TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  pipeline_hazard_ctrl_if hz();
  pipeline_hazard_ctrl #(.TIMEOUT(TO)) dut (.clk(clk), .reset(rst), .hz(hz));
  always #5 clk = ~clk;
  int errs = 0;
  int checks = 0;
  logic [5:0]  out_q[$];
  logic [64:0] cnt_q[$];
  logic        m_sh = 1'b0;
  logic [15:0] m_w = 16'd0;
  logic        m_to = 1'b0;
  logic [31:0] m_sc = 32'd0;
  logic [31:0] m_rc = 32'd0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, q, y, b, input logic [4:0] rd = 0, r1 = 0, r2 = 0,
                     input logic ld = 0, we = 0, u1 = 0, u2 = 0);
    logic mw, lu;
    logic [5:0] o, e;
    logic [64:0] c;
    rst = r; hz.mem_req = q; hz.mem_ready = y; hz.redirect_EX = b;
    hz.rd_EX = rd; hz.rs1_dec = r1; hz.rs2_dec = r2; hz.load_EX = ld;
    hz.rf_wr_en_EX = we; hz.rs1_used_dec = u1; hz.rs2_used_dec = u2;
    mw = q & !y;
    lu = ld & we & (rd != 0) & ((u1 && r1 == rd) || (u2 && r2 == rd));
    o = mw ? 6'b101011 : m_sh ? 6'b010000 : b ? 6'b010100 : lu ? 6'b100100 : 6'b000000;
    out_q.push_back(o);
    if (r) begin
      m_sh = 0; m_w = 0; m_to = 0; m_sc = 0; m_rc = 0;
    end else begin
      m_sc += {31'd0, o[5]};
      if (!mw && !m_sh && b) m_rc++;
      m_w = mw ? ((m_w == 16'hFFFF) ? m_w : m_w + 16'd1) : 16'd0;
      if (m_w == 16'(TO)) m_to = 1;
      m_sh = mw ? m_sh : (!m_sh && b);
    end
    cnt_q.push_back({m_to, m_sc, m_rc});
    #1;
    e = out_q.pop_front();
    check("outs", {58'd0, hz.stall_fe, hz.flush_if, hz.stall_idc, hz.flush_idc, hz.stall_ex, hz.stall_mem}, {58'd0, e});
    check("excl", {62'd0, hz.stall_idc & hz.flush_idc, hz.stall_fe & hz.flush_if}, 64'd0);
    @(posedge clk);
    #1;
    c = cnt_q.pop_front();
    check("mem_timeout", {63'd0, hz.mem_timeout}, {63'd0, c[64]});
    check("stall_cycles", {32'd0, hz.stall_cycles}, {32'd0, c[63:32]});
    check("redirect_count", {32'd0, hz.redirect_count}, {32'd0, c[31:0]});
    @(negedge clk);
  endtask
  task automatic idle();
    cyc(0, 0, 1, 0);
  endtask
  initial begin
    hz.mem_req = 0; hz.mem_ready = 1; hz.redirect_EX = 0; hz.rd_EX = 0; hz.rs1_dec = 0;
    hz.rs2_dec = 0; hz.load_EX = 0; hz.rf_wr_en_EX = 0; hz.rs1_used_dec = 0; hz.rs2_used_dec = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_timeout", {63'd0, hz.mem_timeout}, 64'd0);
    check("rst_stall", {32'd0, hz.stall_cycles}, 64'd0);
    check("rst_redir", {32'd0, hz.redirect_count}, 64'd0);
    cyc(0, 0, 1, 0, 5, 5, 0, 1, 1, 1, 0);
    idle();
    check("lu_stall_cycles", {32'd0, hz.stall_cycles}, 64'd1);
    cyc(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1);
    cyc(0, 0, 1, 0, 7, 3, 7, 1, 1, 1, 1);
    cyc(0, 0, 1, 0, 7, 7, 7, 1, 1, 0, 0);
    cyc(0, 0, 1, 0, 7, 7, 0, 0, 1, 1, 0);
    check("x0_no_stall", {32'd0, hz.stall_cycles}, 64'd2);
    cyc(0, 0, 1, 1);
    idle();
    idle();
    check("redir_count1", {32'd0, hz.redirect_count}, 64'd1);
    repeat (3) cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 1);
    idle();
    check("memwait_redir", {32'd0, hz.redirect_count}, 64'd2);
    check("memwait_stall", {32'd0, hz.stall_cycles}, 64'd5);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1, 4, 4, 0, 1, 1, 1, 0);
    idle();
    check("shadow_ignored", {32'd0, hz.redirect_count}, 64'd3);
    cyc(0, 0, 1, 1);
    repeat (2) cyc(0, 1, 0, 0);
    idle();
    idle();
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0);
      check("timeout_seq", {63'd0, hz.mem_timeout}, {63'd0, i >= 3});
    end
    cyc(0, 1, 1, 0);
    check("timeout_sticky", {63'd0, hz.mem_timeout}, 64'd1);
    cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 0);
    check("timeout_reset", {63'd0, hz.mem_timeout}, 64'd0);
    idle();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    m_sc = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    cyc(0, 0, 1, 0, 9, 0, 9, 1, 1, 0, 1);
    check("stall_wrap", {32'd0, hz.stall_cycles}, 64'd0);
    for (int i = 0; i < 80; i++)
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 4) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
